// File: rtl/proc_clk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// proc_clk_ctrl_pkg
// Shared definitions for the processor clock-control stage: FSM state
// encodings (also shown on the panel LEDs) and default parameter values
// shared by the top level and the divider wrapper.
// No ports.
// ---------------------------------------------------------------------------
package proc_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  // Consecutive stable inclk cycles before a button level change is accepted.
  localparam logic [15:0] DEB_CYCLES_DEF = 16'd50000;

  // Default width of the executed-cycle counter.
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/proc_clk_ctrl_if.sv
// ---------------------------------------------------------------------------
// proc_clk_ctrl_if
// Panel/processor-side signal bundle of the clock-control stage.
//   run_sw      run switch, level, asynchronous
//   step_btn    raw single-step pushbutton, active-high, bouncing
//   halt_req    processor END/halt indication, synchronous to inclk
//   resume      one-cycle pulse that clears HALT
//   div_ena     enable to the slow-clock divider
//   proc_ce     processor clock-enable, one inclk cycle wide
//   state       current FSM state, for LEDs
//   cycle_count number of proc_ce pulses issued
// Modports: master = clock controller, slave = panel/processor side.
// ---------------------------------------------------------------------------
interface proc_clk_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             run_sw;
  logic             step_btn;
  logic             halt_req;
  logic             resume;
  logic             div_ena;
  logic             proc_ce;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  run_sw, step_btn, halt_req, resume,
    output div_ena, proc_ce, state, cycle_count
  );

  modport slave (
    output run_sw, step_btn, halt_req, resume,
    input  div_ena, proc_ce, state, cycle_count
  );

endinterface

// File: rtl/proc_clk_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw, bouncing pushbutton into the inclk domain, accepts a
// level change only after DEB_CYCLES consecutive stable cycles, and emits a
// one-cycle event on each accepted 0->1 change. Reused for other panel
// buttons.
//   inclk  system clock
//   rst_n  asynchronous active-low reset
//   raw    raw button input, asynchronous
//   level  debounced button level
//   evt    one-cycle pulse on an accepted press
// ---------------------------------------------------------------------------
module btn_debounce
  import proc_clk_ctrl_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic inclk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic evt
);

  logic        raw_meta;
  logic        raw_s;
  logic [15:0] stable_cnt;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      raw_meta <= 1'b0;
      raw_s    <= 1'b0;
    end else begin
      raw_meta <= raw;
      raw_s    <= raw_meta;
    end
  end

  // The counter only runs while the synced input disagrees with the accepted
  // level; any agreement restarts it, so bounces shorter than DEB_CYCLES are
  // swallowed. The event fires only when the new accepted level is 1.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= 16'd0;
      level      <= 1'b0;
      evt        <= 1'b0;
    end else if (raw_s == level) begin
      stable_cnt <= 16'd0;
      evt        <= 1'b0;
    end else if (stable_cnt >= DEB_CYCLES - 16'd1) begin
      stable_cnt <= 16'd0;
      level      <= raw_s;
      evt        <= raw_s;
    end else begin
      stable_cnt <= stable_cnt + 16'd1;
      evt        <= 1'b0;
    end
  end

endmodule

// File: rtl/proc_clk_ctrl.sv
// ---------------------------------------------------------------------------
// proc_clk_ctrl
// Processor clock-control stage downstream of the slow-clock divider. Turns
// each slow_clk rising edge into a one-inclk-cycle processor clock-enable
// while running, supports single-step and halt, drives the divider enable
// and counts executed cycles for the display.
//   inclk     system clock; all logic on its rising edge
//   rst_n     asynchronous active-low reset
//   slow_clk  slow clock from the divider, asynchronous to inclk
//   bus       proc_clk_ctrl_if master: run_sw, step_btn, halt_req, resume in;
//             div_ena, proc_ce, state, cycle_count out
// ---------------------------------------------------------------------------
module proc_clk_ctrl
  import proc_clk_ctrl_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int          CNT_W      = CNT_W_DEF
) (
  input  logic                  inclk,
  input  logic                  rst_n,
  input  logic                  slow_clk,
  proc_clk_ctrl_if.master       bus
);

  state_t           state_q;
  state_t           state_d;
  logic             proc_ce_q;
  logic             proc_ce_d;
  logic             div_ena_q;
  logic             div_ena_d;
  logic [CNT_W-1:0] count_q;

  logic sclk_meta, sclk_s, sclk_prev;
  logic run_meta, run_sw_s;
  logic rise;
  logic step_evt;
  logic step_level_unused;

  // Debounced press events for single-step; the level itself is not needed
  // here because the FSM reacts only to the press edge.
  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_step_deb (
    .inclk (inclk),
    .rst_n (rst_n),
    .raw   (bus.step_btn),
    .level (step_level_unused),
    .evt   (step_evt)
  );

  // Synchronisers for slow_clk and run_sw, plus the slow_clk edge register.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_prev <= 1'b0;
      run_meta  <= 1'b0;
      run_sw_s  <= 1'b0;
    end else begin
      sclk_meta <= slow_clk;
      sclk_s    <= sclk_meta;
      sclk_prev <= sclk_s;
      run_meta  <= bus.run_sw;
      run_sw_s  <= run_meta;
    end
  end

  assign rise = sclk_s & ~sclk_prev;

  // State and registered outputs.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      proc_ce_q <= 1'b0;
      div_ena_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      proc_ce_q <= proc_ce_d;
      div_ena_q <= div_ena_d;
    end
  end

  // Next state and next outputs. The pulse for a step is registered on entry
  // to STEP so it is high exactly while STEP is the current state. In RUN a
  // halt request beats a same-cycle rise, and dropping run_sw discards it.
  always_comb begin
    state_d   = state_q;
    proc_ce_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_sw_s) begin
          state_d = ST_RUN;
        end else if (step_evt) begin
          state_d   = ST_STEP;
          proc_ce_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
        end else if (!run_sw_s) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          proc_ce_d = 1'b1;
        end
      end
      ST_STEP: begin
        state_d = bus.halt_req ? ST_HALT : ST_IDLE;
      end
      ST_HALT: begin
        if (bus.resume) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    div_ena_d = (state_d == ST_RUN);
  end

  // Executed-cycle counter; wraps silently, cleared by resume out of HALT.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (state_q == ST_HALT && bus.resume) begin
      count_q <= '0;
    end else if (proc_ce_q) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.state       = state_q;
  assign bus.proc_ce     = proc_ce_q;
  assign bus.div_ena     = div_ena_q;
  assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_proc_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_proc_clk_ctrl
// Self-checking bench for proc_clk_ctrl with a short debounce (4 cycles) and
// a 4-bit cycle counter so wrap-around is reachable. Expected values come
// from an event-level model: every stimulus event that should execute a
// processor cycle bumps a modulo-16 counter, which is cleared on reset and
// on resume.
// ---------------------------------------------------------------------------
module tb_proc_clk_ctrl;
  import proc_clk_ctrl_pkg::*;

  localparam int          CNT_W = 4;
  localparam logic [15:0] DEB   = 16'd4;
  localparam int          WRAP  = 1 << CNT_W;

  logic inclk    = 1'b0;
  logic rst_n    = 1'b0;
  logic slow_clk = 1'b0;

  int checks      = 0;
  int errors      = 0;
  int pulse_cnt   = 0;
  int model_count = 0;
  bit prev_ce     = 1'b0;
  bit double_seen = 1'b0;

  proc_clk_ctrl_if #(.CNT_W(CNT_W)) bus ();

  proc_clk_ctrl #(
    .DEB_CYCLES (DEB),
    .CNT_W      (CNT_W)
  ) dut (
    .inclk    (inclk),
    .rst_n    (rst_n),
    .slow_clk (slow_clk),
    .bus      (bus)
  );

  always #5 inclk = ~inclk;

  // Advance one cycle and sample just after the edge; tally pulses and note
  // any pulse lasting two cycles.
  task automatic tick();
    @(posedge inclk);
    #1;
    if (bus.proc_ce === 1'b1) begin
      pulse_cnt++;
      if (prev_ce) double_seen = 1'b1;
    end
    prev_ce = (bus.proc_ce === 1'b1);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Bouncy press: a few single-cycle 1/0 glitches, then a solid hold,
  // then a bouncy release and a solid low.
  task automatic press_step(input int hold);
    int k;
    k = $urandom_range(2, 4);
    repeat (k) begin
      bus.step_btn = 1'b1; tick();
      bus.step_btn = 1'b0; tick();
    end
    bus.step_btn = 1'b1;
    ticks(hold);
    repeat (2) begin
      bus.step_btn = 1'b0; tick();
      bus.step_btn = 1'b1; tick();
    end
    bus.step_btn = 1'b0;
    ticks(12);
  endtask

  task automatic test_reset();
    bus.run_sw   = 1'b1;
    bus.step_btn = 1'b0;
    bus.halt_req = 1'b0;
    bus.resume   = 1'b0;
    rst_n        = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) slow_clk = ~slow_clk;
      tick();
      checks++;
      if (bus.state !== 2'b00 || bus.div_ena !== 1'b0 || bus.proc_ce !== 1'b0 ||
          bus.cycle_count !== '0)
        begin
          errors++;
          $display("[TB] FAIL reset_hold: state=%0d div_ena=%0b proc_ce=%0b count=%0d, want 0/0/0/0",
                   bus.state, bus.div_ena, bus.proc_ce, bus.cycle_count);
        end
    end
    bus.run_sw  = 1'b0;
    slow_clk    = 1'b0;
    model_count = 0;
    rst_n       = 1'b1;
    ticks(6);
    checks++;
    if (bus.state !== 2'b00 || bus.div_ena !== 1'b0 || pulse_cnt != 0) begin
      errors++;
      $display("[TB] FAIL reset_release: state=%0d div_ena=%0b pulses=%0d, want 0/0/0",
               bus.state, bus.div_ena, pulse_cnt);
    end
  endtask

  task automatic test_run();
    int half, first, base;
    bit exp_ena;
    bus.run_sw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_ena = (i >= 3);
      checks++;
      if (bus.div_ena !== exp_ena) begin
        errors++;
        $display("[TB] FAIL run_div_ena: cycle %0d div_ena=%0b, want %0b", i, bus.div_ena, exp_ena);
      end
    end
    for (int r = 0; r < 5; r++) begin
      half  = $urandom_range(8, 20);
      first = -1;
      base  = pulse_cnt;
      slow_clk = 1'b1;
      for (int i = 1; i <= half; i++) begin
        tick();
        if (bus.proc_ce === 1'b1 && first < 0) first = i;
      end
      slow_clk = 1'b0;
      ticks(half);
      model_count = (model_count + 1) % WRAP;
      checks++;
      if (first < 3 || first > 4) begin
        errors++;
        $display("[TB] FAIL run_latency: rise %0d latency=%0d cycles, want 3 or 4", r, first);
      end
      checks++;
      if (pulse_cnt - base != 1) begin
        errors++;
        $display("[TB] FAIL run_pulse_count: rise %0d pulses=%0d, want 1", r, pulse_cnt - base);
      end
    end
    checks++;
    if (bus.cycle_count !== CNT_W'(model_count)) begin
      errors++;
      $display("[TB] FAIL run_cycle_count: count=%0d, want %0d", bus.cycle_count, model_count);
    end
    bus.run_sw = 1'b0;
    ticks(4);
    checks++;
    if (bus.state !== 2'b00 || bus.div_ena !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_exit: state=%0d div_ena=%0b, want 0/0", bus.state, bus.div_ena);
    end
  endtask

  task automatic test_step_debounce();
    int base;
    int k;
    base = pulse_cnt;
    k = $urandom_range(2, 4);
    repeat (k) begin
      bus.step_btn = 1'b1; tick();
      bus.step_btn = 1'b0; tick();
    end
    bus.step_btn = 1'b1;
    ticks(10);
    model_count = (model_count + 1) % WRAP;
    checks++;
    if (pulse_cnt - base != 1 || bus.state !== 2'b00) begin
      errors++;
      $display("[TB] FAIL step_first_press: pulses=%0d state=%0d, want 1/0", pulse_cnt - base, bus.state);
    end
    base = pulse_cnt;
    ticks(100);
    checks++;
    if (pulse_cnt - base != 0) begin
      errors++;
      $display("[TB] FAIL step_held: pulses=%0d, want 0", pulse_cnt - base);
    end
    base = pulse_cnt;
    repeat (2) begin
      bus.step_btn = 1'b0; tick();
      bus.step_btn = 1'b1; tick();
    end
    bus.step_btn = 1'b0;
    ticks(12);
    checks++;
    if (pulse_cnt - base != 0) begin
      errors++;
      $display("[TB] FAIL step_release: pulses=%0d, want 0", pulse_cnt - base);
    end
    base = pulse_cnt;
    press_step(10);
    model_count = (model_count + 1) % WRAP;
    checks++;
    if (pulse_cnt - base != 1) begin
      errors++;
      $display("[TB] FAIL step_second_press: pulses=%0d, want 1", pulse_cnt - base);
    end
    checks++;
    if (bus.cycle_count !== CNT_W'(model_count)) begin
      errors++;
      $display("[TB] FAIL step_cycle_count: count=%0d, want %0d", bus.cycle_count, model_count);
    end
  endtask

  task automatic test_halt();
    int base;
    bus.run_sw = 1'b1;
    ticks(4);
    checks++;
    if (bus.state !== 2'b01) begin
      errors++;
      $display("[TB] FAIL halt_enter_run: state=%0d, want 1", bus.state);
    end
    base = pulse_cnt;
    slow_clk = 1'b1;
    ticks(2);
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    checks++;
    if (bus.state !== 2'b11 || bus.div_ena !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_state: state=%0d div_ena=%0b, want 3/0", bus.state, bus.div_ena);
    end
    ticks(6);
    checks++;
    if (pulse_cnt - base != 0) begin
      errors++;
      $display("[TB] FAIL halt_priority: pulses=%0d, want 0", pulse_cnt - base);
    end
    for (int k = 0; k < 5; k++) begin
      slow_clk = ~slow_clk;
      ticks($urandom_range(8, 15));
    end
    slow_clk = 1'b0;
    press_step(10);
    bus.run_sw = 1'b0;
    ticks(5);
    checks++;
    if (pulse_cnt - base != 0 || bus.state !== 2'b11 || bus.cycle_count !== CNT_W'(model_count)) begin
      errors++;
      $display("[TB] FAIL halt_ignore: pulses=%0d state=%0d count=%0d, want 0/3/%0d",
               pulse_cnt - base, bus.state, bus.cycle_count, model_count);
    end
    bus.resume = 1'b1;
    tick();
    bus.resume  = 1'b0;
    model_count = 0;
    checks++;
    if (bus.state !== 2'b00 || bus.cycle_count !== CNT_W'(model_count)) begin
      errors++;
      $display("[TB] FAIL halt_resume: state=%0d count=%0d, want 0/0", bus.state, bus.cycle_count);
    end
  endtask

  task automatic test_wrap();
    int base;
    for (int n = 0; n < 17; n++) begin
      base = pulse_cnt;
      press_step($urandom_range(8, 12));
      model_count = (model_count + 1) % WRAP;
      checks++;
      if (pulse_cnt - base != 1 || bus.cycle_count !== CNT_W'(model_count)) begin
        errors++;
        $display("[TB] FAIL wrap_step: step %0d pulses=%0d count=%0d, want 1/%0d",
                 n, pulse_cnt - base, bus.cycle_count, model_count);
      end
    end
  endtask

  task automatic test_run_idle_race();
    int base;
    bus.run_sw = 1'b1;
    ticks(4);
    base = pulse_cnt;
    press_step(10);
    checks++;
    if (pulse_cnt - base != 0 || bus.state !== 2'b01) begin
      errors++;
      $display("[TB] FAIL run_ignores_step: pulses=%0d state=%0d, want 0/1", pulse_cnt - base, bus.state);
    end
    base = pulse_cnt;
    slow_clk   = 1'b1;
    bus.run_sw = 1'b0;
    ticks(8);
    checks++;
    if (pulse_cnt - base != 0 || bus.state !== 2'b00 || bus.cycle_count !== CNT_W'(model_count)) begin
      errors++;
      $display("[TB] FAIL run_idle_race: pulses=%0d state=%0d count=%0d, want 0/0/%0d",
               pulse_cnt - base, bus.state, bus.cycle_count, model_count);
    end
    slow_clk = 1'b0;
    ticks(4);
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    bus.run_sw = 1'b1;
    ticks(4);
    slow_clk = 1'b1;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (bus.proc_ce === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL async_reset_pulse: proc_ce=0 after 8 cycles, want a pulse");
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_count = 0;
    checks++;
    if (bus.proc_ce !== 1'b0 || bus.state !== 2'b00 || bus.div_ena !== 1'b0 ||
        bus.cycle_count !== CNT_W'(model_count))
      begin
        errors++;
        $display("[TB] FAIL async_reset: proc_ce=%0b state=%0d div_ena=%0b count=%0d, want 0/0/0/0",
                 bus.proc_ce, bus.state, bus.div_ena, bus.cycle_count);
      end
    bus.run_sw = 1'b0;
    slow_clk   = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(3);
  endtask

  task automatic test_pulse_width();
    checks++;
    if (double_seen) begin
      errors++;
      $display("[TB] FAIL pulse_width: proc_ce high two cycles in a row, want single-cycle pulses");
    end
  endtask

  initial begin
    bus.run_sw   = 1'b0;
    bus.step_btn = 1'b0;
    bus.halt_req = 1'b0;
    bus.resume   = 1'b0;
    test_reset();
    test_run();
    test_step_debounce();
    test_halt();
    test_wrap();
    test_run_idle_race();
    test_async_reset();
    test_pulse_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
